// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serialises instruction fetches and data accesses
// onto one RAM port, data first, and returns registered one-cycle hit pulses.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; grants data before fetch
//   IACC  | fetch strobe active; aborts if the fetch request is redirected
//   DACC  | data read/write strobe active; never aborts
//   IRSP  | ihit pulse cycle
//   DRSP  | dhit pulse cycle
//   ERR   | RAM timed out; everything ignored until reset
module memory_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              mem_err
);

   typedef enum logic [2:0] {IDLE, IACC, DACC, IRSP, DRSP, ERR} state_t;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] store_q;
   logic              wr_q;
   logic [CNT_W-1:0]  cnt;
   logic              i_abort;

   // A fetch is abandoned as soon as the requester drops or redirects it.
   assign i_abort = !iREN || (iaddr != addr_q);

   // Strobes are decoded combinationally so an aborted fetch drops ramREN in
   // the same cycle; address/data are forced to 0 whenever no strobe is up.
   assign ramREN   = ((state == IACC) && !i_abort) || ((state == DACC) && !wr_q);
   assign ramWEN   = (state == DACC) && wr_q;
   assign ramaddr  = (ramREN || ramWEN) ? addr_q : '0;
   assign ramstore = ramWEN ? store_q : '0;

   // Arbitration FSM with registered hit pulses, load data and error flag.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         addr_q  <= '0;
         store_q <= '0;
         wr_q    <= 1'b0;
         cnt     <= '0;
         ihit    <= 1'b0;
         dhit    <= 1'b0;
         iload   <= '0;
         dload   <= '0;
         mem_err <= 1'b0;
      end else begin
         ihit <= 1'b0;
         dhit <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (dREN || dWEN) begin
                  state   <= DACC;
                  addr_q  <= daddr;
                  store_q <= dstore;
                  wr_q    <= dWEN;
               end else if (iREN) begin
                  state  <= IACC;
                  addr_q <= iaddr;
                  wr_q   <= 1'b0;
               end
            end
            IACC: begin
               if (i_abort) begin
                  state <= IDLE;
               end else if (ram_ready) begin
                  iload <= ramload;
                  ihit  <= 1'b1;
                  state <= IRSP;
               end else if (cnt == TMO) begin
                  mem_err <= 1'b1;
                  state   <= ERR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DACC: begin
               if (ram_ready) begin
                  if (!wr_q) dload <= ramload;
                  dhit  <= 1'b1;
                  state <= DRSP;
               end else if (cnt == TMO) begin
                  mem_err <= 1'b1;
                  state   <= ERR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            IRSP:    state <= IDLE;
            DRSP:    state <= IDLE;
            ERR:     state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a transaction-level reference model is
// compared against every output on each falling edge, plus hand-computed
// spot checks along the stimulus sequence.
module tb_memory_arbiter;

   localparam int TIMEOUT = 255;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic        ihit;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic        dhit;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload = '0;
   logic        ram_ready = 1'b0;
   logic        mem_err;

   int n_chk = 0;
   int n_fail = 0;

   memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: which transaction is in flight (0 none, 1 fetch, 2 data),
   // which hit is due this cycle, how long the RAM has kept us waiting.
   int          m_busy = 0;
   int          m_rsp = 0;
   int          m_wait = 0;
   logic        m_dead = 1'b0;
   logic        m_wr = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_store = '0;
   logic [31:0] m_iload = '0;
   logic [31:0] m_dload = '0;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_busy  <= 0;
         m_rsp   <= 0;
         m_wait  <= 0;
         m_dead  <= 1'b0;
         m_iload <= '0;
         m_dload <= '0;
      end else if (!m_dead) begin
         m_rsp <= 0;
         if (m_rsp == 0) begin
            if (m_busy == 0) begin
               m_wait <= 0;
               if (dREN || dWEN) begin
                  m_busy  <= 2;
                  m_addr  <= daddr;
                  m_store <= dstore;
                  m_wr    <= dWEN;
               end else if (iREN) begin
                  m_busy <= 1;
                  m_addr <= iaddr;
                  m_wr   <= 1'b0;
               end
            end else if (m_busy == 1 && !(iREN && iaddr == m_addr)) begin
               m_busy <= 0;
            end else if (ram_ready) begin
               m_rsp  <= m_busy;
               m_busy <= 0;
               if (m_busy == 1) m_iload <= ramload;
               else if (!m_wr) m_dload <= ramload;
            end else if (m_wait == TIMEOUT) begin
               m_dead <= 1'b1;
               m_busy <= 0;
            end else begin
               m_wait <= m_wait + 1;
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge CLK) begin
      logic        live_f;
      logic        e_ren;
      logic        e_wen;
      live_f = (m_busy == 1) && iREN && (iaddr == m_addr);
      e_ren  = live_f || (m_busy == 2 && !m_wr);
      e_wen  = (m_busy == 2) && m_wr;
      chk1 ("m_ihit",     ihit,     m_rsp == 1);
      chk1 ("m_dhit",     dhit,     m_rsp == 2);
      chk1 ("m_hit_excl", ihit && dhit, 1'b0);
      chk32("m_iload",    iload,    m_iload);
      chk32("m_dload",    dload,    m_dload);
      chk1 ("m_ramREN",   ramREN,   e_ren);
      chk1 ("m_ramWEN",   ramWEN,   e_wen);
      chk32("m_ramaddr",  ramaddr,  (e_ren || e_wen) ? m_addr : 32'h0);
      chk32("m_ramstore", ramstore, e_wen ? m_store : 32'h0);
      chk1 ("m_mem_err",  mem_err,  m_dead);
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic at_neg();
      @(negedge CLK);
   endtask

   task automatic all_zero(input string name);
      chk32({name, "_out"},
            {20'h0, ihit, dhit, ramREN, ramWEN, mem_err, 7'h0} | iload | dload | ramaddr | ramstore,
            32'h0);
   endtask

   initial begin
      // reset
      repeat (2) cyc();
      at_neg();
      all_zero("reset");
      cyc();
      nRST = 1'b1;

      // fetch: ready on the 3rd strobe cycle
      iREN = 1'b1; iaddr = 32'h100; ramload = 32'hDEADBEEF;
      cyc(); at_neg(); chk1("f_ren1", ramREN, 1'b1); chk32("f_addr1", ramaddr, 32'h100);
      cyc(); at_neg(); chk1("f_ren2", ramREN, 1'b1);
      cyc(); ram_ready = 1'b1; at_neg(); chk1("f_ren3", ramREN, 1'b1); chk1("f_nohit3", ihit, 1'b0);
      cyc(); ram_ready = 1'b0; iREN = 1'b0;
      at_neg(); chk1("f_ihit", ihit, 1'b1); chk32("f_iload", iload, 32'hDEADBEEF); chk1("f_ren_rsp", ramREN, 1'b0);
      cyc(); at_neg(); chk1("f_ihit_drop", ihit, 1'b0); chk32("f_iload_hold", iload, 32'hDEADBEEF);

      // priority: data write wins over a simultaneous fetch
      iREN = 1'b1; iaddr = 32'h500; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234;
      ramload = 32'h5555; ram_ready = 1'b1;
      cyc(); at_neg(); chk1("p_wen", ramWEN, 1'b1); chk1("p_ren", ramREN, 1'b0);
      chk32("p_addr", ramaddr, 32'h200); chk32("p_store", ramstore, 32'h1234);
      cyc(); dWEN = 1'b0; at_neg(); chk1("p_dhit", dhit, 1'b1); chk1("p_ihit0", ihit, 1'b0);
      cyc(); at_neg(); chk1("p_gap_dhit", dhit, 1'b0); chk1("p_gap_ren", ramREN, 1'b0);
      cyc(); at_neg(); chk1("p_fren", ramREN, 1'b1); chk32("p_faddr", ramaddr, 32'h500);
      cyc(); iREN = 1'b0; ram_ready = 1'b0;
      at_neg(); chk1("p_ihit", ihit, 1'b1); chk32("p_iload", iload, 32'h5555); chk1("p_dhit0", dhit, 1'b0);
      cyc();

      // abort: fetch redirected mid-access
      iREN = 1'b1; iaddr = 32'h100;
      cyc(); at_neg(); chk1("a_ren", ramREN, 1'b1);
      cyc(); iaddr = 32'h300; at_neg(); chk1("a_drop", ramREN, 1'b0); chk32("a_addr0", ramaddr, 32'h0);
      cyc(); at_neg(); chk1("a_noihit", ihit, 1'b0);
      cyc(); ramload = 32'h3003; ram_ready = 1'b1;
      at_neg(); chk1("a_ren2", ramREN, 1'b1); chk32("a_addr2", ramaddr, 32'h300);
      cyc(); iREN = 1'b0; ram_ready = 1'b0;
      at_neg(); chk1("a_ihit", ihit, 1'b1); chk32("a_iload", iload, 32'h3003);
      cyc();

      // read then read+write (write wins)
      dREN = 1'b1; daddr = 32'h40; ramload = 32'hCAFE;
      cyc(); at_neg(); chk1("r_ren", ramREN, 1'b1); chk1("r_wen", ramWEN, 1'b0); chk32("r_addr", ramaddr, 32'h40);
      ram_ready = 1'b1;
      cyc(); dREN = 1'b0; ram_ready = 1'b0;
      at_neg(); chk1("r_dhit", dhit, 1'b1); chk32("r_dload", dload, 32'hCAFE);
      cyc(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'hBEEF; ramload = 32'h9999;
      cyc(); at_neg(); chk1("w_wen", ramWEN, 1'b1); chk1("w_ren", ramREN, 1'b0); chk32("w_store", ramstore, 32'hBEEF);
      ram_ready = 1'b1;
      cyc(); dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
      at_neg(); chk1("w_dhit", dhit, 1'b1); chk32("w_dload_hold", dload, 32'hCAFE);
      cyc();

      // ready on the last strobe cycle before timeout still completes
      dREN = 1'b1; daddr = 32'h80; ramload = 32'h7777;
      cyc();
      repeat (TIMEOUT) cyc();
      ram_ready = 1'b1;
      at_neg(); chk1("tb_ren", ramREN, 1'b1); chk1("tb_err0", mem_err, 1'b0);
      cyc(); dREN = 1'b0; ram_ready = 1'b0;
      at_neg(); chk1("tb_dhit", dhit, 1'b1); chk32("tb_dload", dload, 32'h7777); chk1("tb_err1", mem_err, 1'b0);
      cyc();

      // timeout: sticky error, requests ignored
      dREN = 1'b1; daddr = 32'h90;
      cyc();
      repeat (TIMEOUT) cyc();
      at_neg(); chk1("t_last_ren", ramREN, 1'b1); chk1("t_last_err", mem_err, 1'b0);
      cyc(); at_neg(); chk1("t_err", mem_err, 1'b1); chk1("t_dhit", dhit, 1'b0); chk1("t_ren0", ramREN, 1'b0);
      iREN = 1'b1; ram_ready = 1'b1;
      repeat (3) cyc();
      at_neg(); chk1("t_sticky", mem_err, 1'b1); chk1("t_ign_ihit", ihit, 1'b0);
      chk1("t_ign_ren", ramREN, 1'b0); chk1("t_ign_dhit", dhit, 1'b0);

      // reset clears the error asynchronously
      cyc(); nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
      #1; chk1("x_err_clr", mem_err, 1'b0); all_zero("x_rst");
      cyc(); nRST = 1'b1;

      // reset mid-fetch: strobe drops at once, no hit afterwards
      iREN = 1'b1; iaddr = 32'h600;
      cyc(); at_neg(); chk1("x_ren", ramREN, 1'b1);
      #1 nRST = 1'b0;
      #1 all_zero("x_mid");
      cyc(); nRST = 1'b1; iREN = 1'b0;
      at_neg(); chk1("x_noihit", ihit, 1'b0);
      cyc();

      // normal service after recovery
      dREN = 1'b1; daddr = 32'hA0; ramload = 32'hABCD; ram_ready = 1'b1;
      cyc(); cyc(); dREN = 1'b0; ram_ready = 1'b0;
      at_neg(); chk1("y_dhit", dhit, 1'b1); chk32("y_dload", dload, 32'hABCD);
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
